// File: rtl/rotary_pkg.sv
// +--------------------------------------------------------------------------+
// | rotary_pkg: command codes, FSM states, detent Gray tables, LFSR constants |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package rotary_pkg;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_LEFT  = 2'b01;
   localparam logic [1:0] CMD_RIGHT = 2'b10;
   localparam logic [1:0] CMD_PRESS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ROT     = 2'd1,
      ST_PRESS   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // {B,A} per phase, phase 0 in the low bits
   localparam logic [7:0] RIGHT_SEQ = {2'b11, 2'b10, 2'b00, 2'b01};
   localparam logic [7:0] LEFT_SEQ  = {2'b11, 2'b01, 2'b00, 2'b10};
   localparam logic [1:0] REST      = 2'b11;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [1:0] seq_val(input logic right, input logic [1:0] idx);
      return right ? RIGHT_SEQ[{idx, 1'b0} +: 2] : LEFT_SEQ[{idx, 1'b0} +: 2];
   endfunction

   function automatic logic [1:0] prev_val(input logic right, input logic [1:0] idx);
      return (idx == 2'd0) ? REST : seq_val(right, idx - 2'd1);
   endfunction

   // Only the line that differs from the previous phase is allowed to chatter.
   function automatic logic [1:0] bounce_mix(input logic [1:0] nom, input logic [1:0] prev,
                                             input logic win, input logic b);
      logic [1:0] mask;
      mask = nom ^ prev;
      return win ? ((nom & ~mask) | (mask & {2{b}})) : nom;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rotary_bounce_lfsr.sv
// +--------------------------------------------------------------------------+
// | rotary_bounce_lfsr: 8-bit Fibonacci LFSR with enable, bit 0 as noise     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module rotary_bounce_lfsr
   import rotary_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED,
   parameter logic [7:0] TAPS = LFSR_TAPS
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic out_bit
);

   logic [7:0] state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else if (en) begin
         state_q <= {state_q[6:0], ^(state_q & TAPS)};
      end
   end

   assign out_bit = state_q[0];

endmodule

`default_nettype wire

// File: rtl/rotary_encoder_emulator.sv
// +--------------------------------------------------------------------------+
// | rotary_encoder_emulator: drives rotA/rotB/rotCenter from detent commands |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module rotary_encoder_emulator
   import rotary_pkg::*;
#(
   parameter int PHASE_CYCLES   = 256,
   parameter int PRESS_CYCLES   = 1024,
   parameter int RELEASE_CYCLES = 1024,
   parameter int BOUNCE_EN      = 0,
   parameter int BOUNCE_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       rotA,
   output logic       rotB,
   output logic       rotCenter
);

   localparam int MAX_A = (PHASE_CYCLES > PRESS_CYCLES) ? PHASE_CYCLES : PRESS_CYCLES;
   localparam int MAX_C = (MAX_A > RELEASE_CYCLES) ? MAX_A : RELEASE_CYCLES;
   localparam int CW    = $clog2(MAX_C) + 1;

   localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES - 1);
   localparam logic [CW-1:0] PR_LAST = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] RL_LAST = CW'(RELEASE_CYCLES - 1);
   localparam logic [CW-1:0] BC      = CW'(BOUNCE_CYCLES);
   localparam logic          BOUNCE_ON = (BOUNCE_EN != 0);
   localparam logic          WIN0      = BOUNCE_ON && (BOUNCE_CYCLES > 0);

   state_t        state;
   logic [1:0]    phase;
   logic [CW-1:0] cnt;
   logic          dir_right;
   logic          noise;
   logic [CW-1:0] cnt_nxt;
   logic          win_nxt;
   logic [1:0]    phase_nxt;

   assign cnt_nxt   = cnt + 1'b1;
   assign win_nxt   = BOUNCE_ON && (cnt_nxt < BC);
   assign phase_nxt = phase + 2'd1;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   rotary_bounce_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .en      (busy && BOUNCE_ON),
      .out_bit (noise)
   );

   // Pins are computed for the cycle that follows each edge, so the window
   // test uses the post-edge counter value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         phase     <= 2'd0;
         cnt       <= '0;
         dir_right <= 1'b0;
         rotA      <= 1'b1;
         rotB      <= 1'b1;
         rotCenter <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cnt   <= '0;
                  phase <= 2'd0;
                  case (cmd)
                     CMD_LEFT, CMD_RIGHT: begin
                        state        <= ST_ROT;
                        dir_right    <= (cmd == CMD_RIGHT);
                        {rotB, rotA} <= bounce_mix(seq_val(cmd == CMD_RIGHT, 2'd0),
                                                   REST, WIN0, noise);
                     end
                     CMD_PRESS: begin
                        state     <= ST_PRESS;
                        rotCenter <= WIN0 ? noise : 1'b1;
                     end
                     default: begin
                        done <= 1'b1;
                     end
                  endcase
               end
            end
            ST_ROT: begin
               if (cnt == PH_LAST) begin
                  cnt <= '0;
                  if (phase == 2'd3) begin
                     state        <= ST_IDLE;
                     done         <= 1'b1;
                     {rotB, rotA} <= REST;
                  end else begin
                     phase        <= phase_nxt;
                     {rotB, rotA} <= bounce_mix(seq_val(dir_right, phase_nxt),
                                                seq_val(dir_right, phase), WIN0, noise);
                  end
               end else begin
                  cnt          <= cnt_nxt;
                  {rotB, rotA} <= bounce_mix(seq_val(dir_right, phase),
                                             prev_val(dir_right, phase), win_nxt, noise);
               end
            end
            ST_PRESS: begin
               if (cnt == PR_LAST) begin
                  cnt       <= '0;
                  state     <= ST_RELEASE;
                  rotCenter <= WIN0 ? noise : 1'b0;
               end else begin
                  cnt       <= cnt_nxt;
                  rotCenter <= win_nxt ? noise : 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt == RL_LAST) begin
                  cnt       <= '0;
                  state     <= ST_IDLE;
                  done      <= 1'b1;
                  rotCenter <= 1'b0;
               end else begin
                  cnt       <= cnt_nxt;
                  rotCenter <= win_nxt ? noise : 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rotary_encoder_emulator.sv
// +--------------------------------------------------------------------------+
// | tb_rotary_encoder_emulator: directed + random checks with a decoder model|
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rotary_encoder_emulator;
   import rotary_pkg::*;

   localparam int PH  = 4;
   localparam int PRC = 600;
   localparam int RLC = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic       cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
   logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
   logic ready0, busy0, done0, rotA0, rotB0, rotCenter0;
   logic ready1, busy1, done1, rotA1, rotB1, rotCenter1;

   int total = 0;
   int passed = 0;

   logic [1:0] right_tab [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
   logic [1:0] left_tab  [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

   logic [1:0] cmd_q [$];
   int exp_r [2] = '{0, 0};
   int exp_l [2] = '{0, 0};
   int exp_d [2] = '{0, 0};

   // decoder model: a detent counts when the lines return to rest having
   // passed through 00; a press counts once the button stays high 8 cycles
   logic [1:0] dec_ba [2];
   logic       dec_seen [2];
   int         dec_run [2];
   int         dec_r [2] = '{0, 0};
   int         dec_l [2] = '{0, 0};
   int         dec_d [2] = '{0, 0};
   int         illegal [2] = '{0, 0};

   always #5 clk = ~clk;

   rotary_encoder_emulator #(
      .PHASE_CYCLES(PH), .PRESS_CYCLES(PRC), .RELEASE_CYCLES(RLC),
      .BOUNCE_EN(0), .BOUNCE_CYCLES(3)
   ) u0 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd(cmd0),
      .cmd_ready(ready0), .busy(busy0), .done(done0),
      .rotA(rotA0), .rotB(rotB0), .rotCenter(rotCenter0)
   );

   rotary_encoder_emulator #(
      .PHASE_CYCLES(PH), .PRESS_CYCLES(PRC), .RELEASE_CYCLES(RLC),
      .BOUNCE_EN(1), .BOUNCE_CYCLES(3)
   ) u1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd(cmd1),
      .cmd_ready(ready1), .busy(busy1), .done(done1),
      .rotA(rotA1), .rotB(rotB1), .rotCenter(rotCenter1)
   );

   task automatic dec(input int i, input logic [1:0] ba, input logic c);
      if (rst) begin
         dec_ba[i] = 2'b11; dec_seen[i] = 1'b0; dec_run[i] = 0;
      end else begin
         if ((ba ^ dec_ba[i]) == 2'b11) illegal[i]++;
         if (ba == 2'b11 && dec_ba[i] != 2'b11) begin
            if (dec_seen[i] && dec_ba[i] == 2'b10) dec_r[i]++;
            if (dec_seen[i] && dec_ba[i] == 2'b01) dec_l[i]++;
            dec_seen[i] = 1'b0;
         end
         if (ba == 2'b00) dec_seen[i] = 1'b1;
         dec_ba[i] = ba;
         dec_run[i] = c ? dec_run[i] + 1 : 0;
         if (dec_run[i] == 8) dec_d[i]++;
      end
   endtask

   always @(negedge clk) begin
      dec(0, {rotB0, rotA0}, rotCenter0);
      dec(1, {rotB1, rotA1}, rotCenter1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int busy_len(input logic [1:0] c);
      if (c == CMD_LEFT || c == CMD_RIGHT) return 4 * PH;
      if (c == CMD_PRESS) return PRC + RLC;
      return 0;
   endfunction

   // {busy, done, cmd_ready, rotCenter, rotB, rotA} at cycle k after acceptance
   function automatic logic [5:0] busy_vec(input logic [1:0] c, input int k);
      logic [1:0] ba;
      logic       cen;
      ba  = 2'b11;
      cen = 1'b0;
      if (c == CMD_RIGHT) ba = right_tab[k / PH];
      if (c == CMD_LEFT)  ba = left_tab[k / PH];
      if (c == CMD_PRESS) cen = (k < PRC);
      return {1'b1, 1'b0, 1'b0, cen, ba};
   endfunction

   task automatic note_cmd(input int i, input logic [1:0] c);
      if (c == CMD_RIGHT) exp_r[i]++;
      if (c == CMD_LEFT)  exp_l[i]++;
      if (c == CMD_PRESS) exp_d[i]++;
   endtask

   // Runs cmd_q on u0 with cmd_valid held high while commands remain.
   task automatic run_queue();
      logic [1:0] c;
      int guard;
      guard = 0;
      while (!ready0 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("ready_wait", {31'd0, ready0}, 32'd1);
      cmd_valid0 = 1'b1;
      cmd0 = cmd_q[0];
      while (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         note_cmd(0, c);
         @(negedge clk);
         if (cmd_q.size() > 0) cmd0 = cmd_q[0];
         else cmd_valid0 = 1'b0;
         for (int k = 0; k < busy_len(c); k++) begin
            check($sformatf("pins_c%0d_k%0d", c, k),
                  {26'd0, busy0, done0, ready0, rotCenter0, rotB0, rotA0},
                  {26'd0, busy_vec(c, k)});
            @(negedge clk);
         end
         check($sformatf("done_c%0d", c),
               {26'd0, busy0, done0, ready0, rotCenter0, rotB0, rotA0}, {26'd0, 6'b011011});
      end
      @(negedge clk);
      check("idle_after", {26'd0, busy0, done0, ready0, rotCenter0, rotB0, rotA0},
            {26'd0, 6'b001011});
   endtask

   task automatic check_counts(input int i, input string tag);
      check({tag, "_right"}, dec_r[i], exp_r[i]);
      check({tag, "_left"},  dec_l[i], exp_l[i]);
      check({tag, "_down"},  dec_d[i], exp_d[i]);
   endtask

   initial begin
      logic [1:0] c;
      int cyc;
      int ndone;

      // reset
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("reset_u0", {26'd0, busy0, done0, ready0, rotCenter0, rotB0, rotA0}, {26'd0, 6'b001011});
      check("reset_u1", {26'd0, busy1, done1, ready1, rotCenter1, rotB1, rotA1}, {26'd0, 6'b001011});
      rst = 1'b0;
      @(negedge clk);

      cmd_q.push_back(CMD_RIGHT);
      run_queue();
      check_counts(0, "right1");

      cmd_q.push_back(CMD_LEFT);
      run_queue();
      check_counts(0, "left1");

      cmd_q.push_back(CMD_NOP);
      run_queue();
      check_counts(0, "nop");

      cmd_q.push_back(CMD_PRESS);
      run_queue();
      check_counts(0, "press");

      // back-to-back with cmd_valid held
      cmd_q.push_back(CMD_RIGHT);
      cmd_q.push_back(CMD_RIGHT);
      cmd_q.push_back(CMD_PRESS);
      run_queue();
      check_counts(0, "b2b");

      for (int n = 0; n < 6; n++) cmd_q.push_back(2'($urandom_range(0, 3)));
      run_queue();
      check_counts(0, "rand_u0");

      // reset during the 2nd cycle of phase 1 of a LEFT
      cmd_valid0 = 1'b1;
      cmd0 = CMD_LEFT;
      @(posedge clk);
      @(negedge clk);
      cmd_valid0 = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_left_pins", {30'd0, rotB0, rotA0}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", {26'd0, busy0, done0, ready0, rotCenter0, rotB0, rotA0}, {26'd0, 6'b001011});
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done0 || busy0) ndone++;
      end
      check("no_done_after_reset", ndone, 0);
      check_counts(0, "after_reset");

      // bounce instance, random commands
      for (int n = 0; n < 20; n++) begin
         c = 2'($urandom_range(0, 3));
         note_cmd(1, c);
         cmd_valid1 = 1'b1;
         cmd1 = c;
         @(posedge clk);
         @(negedge clk);
         cmd_valid1 = 1'b0;
         cyc = 1;
         while (!done1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
         end
         check($sformatf("u1_len_%0d", n), cyc, busy_len(c) + 1);
      end
      repeat (4) @(negedge clk);
      check_counts(1, "bounce");
      check("gray_u1", illegal[1], 0);
      check("gray_u0", illegal[0], 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
